// File: rtl/pkt_buf_writer.sv
// Write-side packetizer for the ping-pong packet buffers.
// Frames a byte-wide pixel stream into fixed-size packets (4-word header plus
// payload) and writes them alternately into buffer A and buffer B. A buffer is
// reused only after the read side reports it drained.
module pkt_buf_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_SIZE   = 60,
  parameter int unsigned HDR_LEN    = 4
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  input  logic                  full_a,
  input  logic                  full_b,
  input  logic                  rd_out_a,
  input  logic                  rd_out_b,
  output logic                  buf_filled_a,
  output logic                  buf_filled_b,
  output logic [7:0]            frame_id,
  output logic                  err
);

  localparam int unsigned PayLen = PKT_SIZE - HDR_LEN;
  localparam int unsigned CntW   = $clog2(PKT_SIZE + 1);

  typedef enum logic [2:0] {
    StWaitBuf,
    StHdr,
    StPayload,
    StClose,
    StCheck
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  wr_en_a_q, wr_en_a_d;
  logic                  wr_en_b_q, wr_en_b_d;
  logic                  sel_q, sel_d;  // 0: buffer A, 1: buffer B
  logic [7:0]            seq_q, seq_d;
  logic [7:0]            frame_id_q, frame_id_d;
  logic                  sof_pend_q, sof_pend_d;
  logic                  err_q, err_d;
  logic                  filled_a_q, filled_a_d;
  logic                  filled_b_q, filled_b_d;

  // [0],[1]: two-stage synchronizer; [2]: previous synchronized value
  logic [2:0]            sync_a_q, sync_b_q;
  logic                  drain_a, drain_b;

  logic [DATA_WIDTH-1:0] hdr_word;
  logic                  tgt_filled;
  logic                  tgt_full;
  logic                  chk_a, chk_b;

  // Bring the read-side drained flags into wr_clk and keep one extra stage for edge detection.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], rd_out_a};
      sync_b_q <= {sync_b_q[1:0], rd_out_b};
    end
  end

  assign drain_a = sync_a_q[1] & ~sync_a_q[2];
  assign drain_b = sync_b_q[1] & ~sync_b_q[2];

  // Select the header word for the current header index.
  always_comb begin
    hdr_word = '0;
    case (cnt_q)
      CntW'(0): hdr_word = DATA_WIDTH'(8'hA5);
      CntW'(1): hdr_word = DATA_WIDTH'(8'h5A);
      CntW'(2): hdr_word = DATA_WIDTH'(frame_id_q);
      CntW'(3): hdr_word = DATA_WIDTH'(seq_q);
      default:  hdr_word = '0;
    endcase
  end

  // Next-state logic: packet FSM, buffer status, counters and error flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    wr_en_a_d  = 1'b0;
    wr_en_b_d  = 1'b0;
    sel_d      = sel_q;
    seq_d      = seq_q;
    frame_id_d = frame_id_q;
    sof_pend_d = sof_pend_q;
    err_d      = err_q;
    filled_a_d = filled_a_q;
    filled_b_d = filled_b_q;
    pix_ready  = 1'b0;

    tgt_filled = sel_q ? filled_b_q : filled_a_q;
    tgt_full   = sel_q ? full_b : full_a;
    chk_a      = (state_q == StCheck) && !sel_q;
    chk_b      = (state_q == StCheck) && sel_q;

    // Drain edges free a buffer; a drain for an already free buffer is a protocol error,
    // except when it lands on the CHECK of that buffer (late drain of the previous packet).
    if (drain_a) begin
      if (!filled_a_q && !chk_a) err_d = 1'b1;
      filled_a_d = 1'b0;
    end
    if (drain_b) begin
      if (!filled_b_q && !chk_b) err_d = 1'b1;
      filled_b_d = 1'b0;
    end

    unique case (state_q)
      StWaitBuf: begin
        if (!tgt_filled && pix_valid) begin
          state_d = StHdr;
          cnt_d   = '0;
        end
      end
      StHdr: begin
        din_d = hdr_word;
        if (sel_q) wr_en_b_d = 1'b1;
        else       wr_en_a_d = 1'b1;
        if (cnt_q == CntW'(HDR_LEN - 1)) begin
          state_d = StPayload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPayload: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          din_d = pix_data;
          if (sel_q) wr_en_b_d = 1'b1;
          else       wr_en_a_d = 1'b1;
          // A new frame starts at this beat; the current packet still completes.
          if (pix_sof) begin
            frame_id_d = frame_id_q + 8'd1;
            sof_pend_d = 1'b1;
          end
          if (cnt_q == CntW'(PayLen - 1)) begin
            state_d = StClose;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StClose: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (!tgt_full) err_d = 1'b1;
        // Applied after the drain handling so the FILLED mark wins a coincident drain.
        if (sel_q) filled_b_d = 1'b1;
        else       filled_a_d = 1'b1;
        sel_d      = ~sel_q;
        seq_d      = sof_pend_q ? 8'd0 : seq_q + 8'd1;
        sof_pend_d = 1'b0;
        state_d    = StWaitBuf;
      end
      default: begin
        state_d = StWaitBuf;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitBuf;
      cnt_q      <= '0;
      din_q      <= '0;
      wr_en_a_q  <= 1'b0;
      wr_en_b_q  <= 1'b0;
      sel_q      <= 1'b0;
      seq_q      <= 8'd0;
      frame_id_q <= 8'd0;
      sof_pend_q <= 1'b0;
      err_q      <= 1'b0;
      filled_a_q <= 1'b0;
      filled_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      wr_en_a_q  <= wr_en_a_d;
      wr_en_b_q  <= wr_en_b_d;
      sel_q      <= sel_d;
      seq_q      <= seq_d;
      frame_id_q <= frame_id_d;
      sof_pend_q <= sof_pend_d;
      err_q      <= err_d;
      filled_a_q <= filled_a_d;
      filled_b_q <= filled_b_d;
    end
  end

  assign din          = din_q;
  assign wr_en_a      = wr_en_a_q;
  assign wr_en_b      = wr_en_b_q;
  assign buf_filled_a = filled_a_q;
  assign buf_filled_b = filled_b_q;
  assign frame_id     = frame_id_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Directed bench for pkt_buf_writer with a simple write-counting buffer stub.
`timescale 1ns/1ps
module tb_pkt_buf_writer;

  localparam int PKT = 60;
  localparam int PAY = 56;

  logic       wr_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_ready;
  logic [7:0] din;
  logic       wr_en_a, wr_en_b;
  logic       full_a, full_b;
  logic       rd_out_a = 1'b0;
  logic       rd_out_b = 1'b0;
  logic       buf_filled_a, buf_filled_b;
  logic [7:0] frame_id;
  logic       err;

  logic       stub_a = 1'b0;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;
  int         wcnt_a, wcnt_b;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         both_hi = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wb_q[$];
  logic [7:0] pk[$];
  int         wa_cyc[$];
  logic       tr_en[$];
  logic [7:0] tr_din[$];

  pkt_buf_writer #(
    .DATA_WIDTH(8),
    .PKT_SIZE  (PKT),
    .HDR_LEN   (4)
  ) dut (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .din         (din),
    .wr_en_a     (wr_en_a),
    .wr_en_b     (wr_en_b),
    .full_a      (full_a),
    .full_b      (full_b),
    .rd_out_a    (rd_out_a),
    .rd_out_b    (rd_out_b),
    .buf_filled_a(buf_filled_a),
    .buf_filled_b(buf_filled_b),
    .frame_id    (frame_id),
    .err         (err)
  );

  always #5 wr_clk = ~wr_clk;

  // Buffer stub: full once PKT words have been written since the last clear.
  always @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_a <= 0;
      wcnt_b <= 0;
    end else begin
      if (clr_a) wcnt_a <= 0;
      else if (wr_en_a) wcnt_a <= wcnt_a + 1;
      if (clr_b) wcnt_b <= 0;
      else if (wr_en_b) wcnt_b <= wcnt_b + 1;
    end
  end
  assign full_a = !stub_a && (wcnt_a >= PKT);
  assign full_b = (wcnt_b >= PKT);

  task automatic tick();
    @(posedge wr_clk);
    #1;
    cyc++;
    if (wr_en_a) begin wa_q.push_back(din); wa_cyc.push_back(cyc); end
    if (wr_en_b) wb_q.push_back(din);
    if (wr_en_a && wr_en_b) both_hi++;
    tr_en.push_back(wr_en_a | wr_en_b);
    tr_din.push_back(din);
  endtask

  task automatic clear_logs();
    wa_q.delete(); wb_q.delete(); wa_cyc.delete(); tr_en.delete(); tr_din.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; stub_a = 1'b0;
    rd_out_a = 1'b0; rd_out_b = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  // Offers n_words payload words base, base+1, ...; gappy toggles pix_valid every cycle.
  task automatic drive_pkt(input int base, input int sof_at, input bit gappy, input int n_words);
    int idx = 0;
    int n = 0;
    bit ph = 1'b1;
    bit acc;
    while (idx < n_words && n < 400) begin
      pix_valid = gappy ? ph : 1'b1;
      pix_data  = 8'(base + idx);
      pix_sof   = (idx == sof_at);
      acc       = pix_valid && pix_ready;
      tick();
      n++;
      if (acc) idx++;
      ph = ~ph;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    if (idx < n_words) begin
      n_tests++; n_fail++;
      $display("FAIL drive_timeout: accepted %0d words, required %0d", idx, n_words);
    end
  endtask

  task automatic write_pkt(input bit to_b, input int base, input int sof_at, input bit gappy,
                           output int other_n);
    int n = 0;
    clear_logs();
    drive_pkt(base, sof_at, gappy, PAY);
    while (((to_b ? buf_filled_b : buf_filled_a) !== 1'b1) && n < 10) begin tick(); n++; end
    if ((to_b ? buf_filled_b : buf_filled_a) !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL filled_timeout: buffer %0d never reported filled", to_b);
    end
    if (to_b) pk = wb_q;
    else      pk = wa_q;
    other_n = to_b ? wa_q.size() : wb_q.size();
  endtask

  task automatic drain_buf(input bit b);
    int n = 0;
    if (b) rd_out_b = 1'b1;
    else   rd_out_a = 1'b1;
    while (((b ? buf_filled_b : buf_filled_a) !== 1'b0) && n < 8) begin tick(); n++; end
    rd_out_a = 1'b0; rd_out_b = 1'b0;
    if ((b ? buf_filled_b : buf_filled_a) !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: buffer %0d still filled", b);
    end
    tick(); tick(); tick();
    if (b) clr_b = 1'b1;
    else   clr_a = 1'b1;
    tick();
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b1;
    tick();
    n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
    n_tests++; if (din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h want 00", din); end
    n_tests++; if ({wr_en_a, wr_en_b} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_en: got %b%b want 00", wr_en_a, wr_en_b); end
    n_tests++; if ({buf_filled_a, buf_filled_b} !== 2'b00) begin n_fail++; $display("FAIL reset_filled: got %b%b want 00", buf_filled_a, buf_filled_b); end
    n_tests++; if (frame_id !== 8'h00) begin n_fail++; $display("FAIL reset_frame_id: got %h want 00", frame_id); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] eh [4];
    logic [7:0] exp;
    int errs = 0;
    int span;
    apply_reset();
    drive_pkt(0, -1, 1'b0, PAY);
    n_tests++; if (wr_en_a !== 1'b1 || din !== 8'h37) begin n_fail++; $display("FAIL basic_last_strobe: got en=%b din=%h want en=1 din=37", wr_en_a, din); end
    tick();
    n_tests++; if (buf_filled_a !== 1'b0) begin n_fail++; $display("FAIL basic_filled_early: got %b want 0", buf_filled_a); end
    tick();
    n_tests++; if (buf_filled_a !== 1'b1) begin n_fail++; $display("FAIL basic_filled_rise: got %b want 1", buf_filled_a); end
    n_tests++; if (wa_q.size() != PKT) begin n_fail++; $display("FAIL basic_strobe_count: got %0d want %0d", wa_q.size(), PKT); end
    span = (wa_cyc.size() == PKT) ? wa_cyc[PKT-1] - wa_cyc[0] : -1;
    n_tests++; if (span != PKT - 1) begin n_fail++; $display("FAIL basic_consecutive: span %0d want %0d", span, PKT - 1); end
    eh = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    for (int i = 0; i < wa_q.size(); i++) begin
      exp = (i < 4) ? eh[i] : 8'(i - 4);
      if (wa_q[i] !== exp) errs++;
    end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL basic_din_seq: %0d wrong words want 0", errs); end
    n_tests++; if (wb_q.size() != 0) begin n_fail++; $display("FAIL basic_no_b_writes: got %0d want 0", wb_q.size()); end
  endtask

  task automatic test_backpressure_drain();
    int other_n;
    int rdy_cnt = 0;
    write_pkt(1'b1, 8'h40, -1, 1'b0, other_n);
    n_tests++; if (pk.size() != PKT) begin n_fail++; $display("FAIL b_pkt_count: got %0d want %0d", pk.size(), PKT); end
    n_tests++; if (pk.size() < 4 || pk[2] !== 8'h00 || pk[3] !== 8'h01 || pk[0] !== 8'hA5 || pk[1] !== 8'h5A)
      begin n_fail++; $display("FAIL b_pkt_header: got size %0d, want A5 5A 00 01", pk.size()); end
    n_tests++; if ({buf_filled_a, buf_filled_b} !== 2'b11) begin n_fail++; $display("FAIL both_filled: got %b%b want 11", buf_filled_a, buf_filled_b); end
    clear_logs();
    pix_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pix_ready) rdy_cnt++;
      tick();
    end
    pix_valid = 1'b0;
    n_tests++; if (rdy_cnt != 0 || tr_en.size() != 8 || wa_q.size() + wb_q.size() != 0)
      begin n_fail++; $display("FAIL stall_both_filled: ready cycles %0d strobes %0d want 0 0", rdy_cnt, wa_q.size() + wb_q.size()); end
    rd_out_a = 1'b1;
    tick();
    n_tests++; if (buf_filled_a !== 1'b1) begin n_fail++; $display("FAIL drain_lat1: got %b want 1", buf_filled_a); end
    tick();
    n_tests++; if (buf_filled_a !== 1'b1) begin n_fail++; $display("FAIL drain_lat2: got %b want 1", buf_filled_a); end
    tick();
    n_tests++; if (buf_filled_a !== 1'b0) begin n_fail++; $display("FAIL drain_lat3: got %b want 0", buf_filled_a); end
    tick(); tick();
    rd_out_a = 1'b0;
    tick(); tick(); tick();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    write_pkt(1'b0, 8'h80, -1, 1'b0, other_n);
    n_tests++; if (pk.size() != PKT || other_n != 0) begin n_fail++; $display("FAIL third_to_a: a %0d b %0d want %0d 0", pk.size(), other_n, PKT); end
    n_tests++; if (pk.size() < 4 || pk[3] !== 8'h02) begin n_fail++; $display("FAIL third_seq: want seq 02"); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL drain_no_err: got %b want 0", err); end
  endtask

  task automatic test_sof();
    int other_n;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      write_pkt(1'(k % 2), 8'(k * 16), -1, 1'b0, other_n);
      drain_buf(1'(k % 2));
    end
    write_pkt(1'b1, 8'h90, 10, 1'b0, other_n);
    n_tests++; if (pk.size() < 4 || pk[2] !== 8'h00 || pk[3] !== 8'h05) begin n_fail++; $display("FAIL sof_pkt_header: want frame 00 seq 05"); end
    n_tests++; if (pk.size() != PKT || pk[PKT-1] !== 8'(8'h90 + PAY - 1)) begin n_fail++; $display("FAIL sof_pkt_complete: got %0d words want %0d ending in %h", pk.size(), PKT, 8'(8'h90 + PAY - 1)); end
    n_tests++; if (frame_id !== 8'h01) begin n_fail++; $display("FAIL sof_frame_id: got %h want 01", frame_id); end
    write_pkt(1'b0, 8'hC0, -1, 1'b0, other_n);
    n_tests++; if (pk.size() < 4 || pk[0] !== 8'hA5 || pk[1] !== 8'h5A || pk[2] !== 8'h01 || pk[3] !== 8'h00)
      begin n_fail++; $display("FAIL sof_next_header: want A5 5A 01 00"); end
  endtask

  task automatic test_gaps();
    int other_n;
    int si[$];
    int gaps = -1;
    int bad = 0;
    int derr = 0;
    apply_reset();
    write_pkt(1'b0, 8'h10, -1, 1'b1, other_n);
    for (int i = 0; i < tr_en.size(); i++) if (tr_en[i]) si.push_back(i);
    n_tests++; if (si.size() != PKT) begin n_fail++; $display("FAIL gap_strobe_count: got %0d want %0d", si.size(), PKT); end
    if (si.size() == PKT) begin
      gaps = 0;
      for (int i = si[4] + 1; i < si[PKT-1]; i++) begin
        if (!tr_en[i]) begin
          gaps++;
          if (tr_din[i] !== tr_din[i-1]) bad++;
        end
      end
    end
    n_tests++; if (gaps != PAY - 1) begin n_fail++; $display("FAIL gap_cycles: got %0d want %0d", gaps, PAY - 1); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL gap_din_hold: got %0d changes want 0", bad); end
    for (int i = 4; i < pk.size(); i++) if (pk[i] !== 8'(8'h10 + i - 4)) derr++;
    n_tests++; if (derr != 0 || pk.size() != PKT) begin n_fail++; $display("FAIL gap_payload: %0d wrong of %0d want 0 of %0d", derr, pk.size(), PKT); end
    n_tests++; if (both_hi != 0) begin n_fail++; $display("FAIL both_strobes: got %0d cycles want 0", both_hi); end
  endtask

  task automatic test_err();
    int other_n;
    apply_reset();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    rd_out_b = 1'b1;
    tick(); tick(); tick(); tick();
    rd_out_b = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_free_drain: got %b want 1", err); end
    apply_reset();
    stub_a = 1'b1;
    write_pkt(1'b0, 8'h00, -1, 1'b0, other_n);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_not_full: got %b want 1", err); end
    rd_out_b = 1'b1;
    tick(); tick(); tick(); tick();
    rd_out_b = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    stub_a = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    int other_n;
    apply_reset();
    write_pkt(1'b0, 8'h00, 0, 1'b0, other_n);
    n_tests++; if (frame_id !== 8'h01 || buf_filled_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: frame %h filled %b want 01 1", frame_id, buf_filled_a); end
    drive_pkt(8'h20, -1, 1'b0, 20);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (pix_ready !== 1'b0 || din !== 8'h00 || wr_en_a !== 1'b0 || wr_en_b !== 1'b0)
      begin n_fail++; $display("FAIL async_reset_bus: ready %b din %h en %b%b want 0 00 00", pix_ready, din, wr_en_a, wr_en_b); end
    n_tests++; if (buf_filled_a !== 1'b0 || buf_filled_b !== 1'b0 || frame_id !== 8'h00 || err !== 1'b0)
      begin n_fail++; $display("FAIL async_reset_status: filled %b%b frame %h err %b want 00 00 0", buf_filled_a, buf_filled_b, frame_id, err); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    write_pkt(1'b0, 8'h30, -1, 1'b0, other_n);
    n_tests++; if (pk.size() != PKT || other_n != 0) begin n_fail++; $display("FAIL post_reset_target: a %0d b %0d want %0d 0", pk.size(), other_n, PKT); end
    n_tests++; if (pk.size() < 4 || pk[0] !== 8'hA5 || pk[1] !== 8'h5A || pk[2] !== 8'h00 || pk[3] !== 8'h00)
      begin n_fail++; $display("FAIL post_reset_header: want A5 5A 00 00"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure_drain();
    test_sof();
    test_gaps();
    test_err();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
